// File: rtl/sqrt_arb_pkg.sv
// Shared types and constants for the BF16 square-root arbiter.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int unsigned BF16_W          = 16;
    localparam int unsigned NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above ptr_i,
// wrapping modulo NumReq. Returns a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap
    logic [IdxW:0] cand;
    logic          found;

    // Scan requesters starting at ptr_i, first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            cand = {1'b0, ptr_i} + (IdxW + 1)'(off);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (!found && req_i[cand[IdxW-1:0]]) begin
                found                  = 1'b1;
                gnt_o[cand[IdxW-1:0]]  = 1'b1;
                idx_o                  = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/sqrt_bf16_arbiter.sv
// Shares one non-pipelined BF16 sqrt unit among NUM_REQ requesters with round-robin
// arbitration and a single operation in flight.
// Optional macro SQRT_ARB_PERF_EN adds busy_cycles / ops_done saturating counters.
module sqrt_bf16_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][BF16_W-1:0] req_operand,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [NUM_REQ-1:0][BF16_W-1:0] rsp_result,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic                           sq_valid_in,
    output logic [BF16_W-1:0]              sq_operand,
    input  logic                           sq_ready_in,
    input  logic                           sq_valid_out,
    input  logic [BF16_W-1:0]              sq_result,
    output logic                           sq_ready_out,
`ifdef SQRT_ARB_PERF_EN
    output logic [31:0]                    busy_cycles,
    output logic [31:0]                    ops_done,
`endif
    output logic                           err_stray
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [BF16_W-1:0]   res_q, res_d;
    logic                err_stray_q, err_stray_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                grant;

    rr_arbiter #(
        .NumReq (NUM_REQ),
        .IdxW   (ID_W)
    ) u_rr_arbiter (
        .req_i  (req_valid),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // A grant needs an idle FSM, a ready unit and at least one valid requester
    assign grant = (state_q == IDLE) && sq_ready_in && (|req_valid);

    // Requester and unit-side outputs; grants are same-cycle, responses come from state
    always_comb begin
        req_ready    = grant ? arb_gnt : '0;
        sq_valid_in  = grant;
        sq_operand   = grant ? req_operand[arb_idx] : '0;
        sq_ready_out = (state_q == WAIT);
        rsp_valid    = '0;
        rsp_result   = '0;
        if (state_q == RESP) begin
            rsp_valid[owner_q]  = 1'b1;
            rsp_result[owner_q] = res_q;
        end
    end

    // Next-state logic for FSM, round-robin pointer, owner tag and result register
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        res_d       = res_q;
        // Any unit result outside WAIT has no owner to go to
        err_stray_d = err_stray_q | (sq_valid_out && (state_q != WAIT));
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d  = arb_idx;
                    rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (sq_valid_out) begin
                    res_d   = sq_result;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            res_q       <= '0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            res_q       <= res_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign err_stray = err_stray_q;

`ifdef SQRT_ARB_PERF_EN
    logic [31:0] busy_cycles_q, busy_cycles_d;
    logic [31:0] ops_done_q, ops_done_d;

    // Saturating performance counters
    always_comb begin
        busy_cycles_d = busy_cycles_q;
        ops_done_d    = ops_done_q;
        if ((state_q != IDLE) && (busy_cycles_q != '1)) begin
            busy_cycles_d = busy_cycles_q + 32'd1;
        end
        if ((state_q == RESP) && rsp_ready[owner_q] && (ops_done_q != '1)) begin
            ops_done_d = ops_done_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_cycles_q <= '0;
            ops_done_q    <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
            ops_done_q    <= ops_done_d;
        end
    end

    assign busy_cycles = busy_cycles_q;
    assign ops_done    = ops_done_q;
`endif

endmodule

// File: tb/tb_sqrt_bf16_arbiter.sv
// Self-checking bench for sqrt_bf16_arbiter: directed test-plan steps followed by a
// randomized phase, checked against a transaction-level model and a sqrt unit stub.
module tb_sqrt_bf16_arbiter;

    localparam int unsigned N = 4;

    logic                CLK = 1'b0;
    logic                nRST;
    logic [N-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N-1:0][15:0]  req_operand, rsp_result;
    logic                sq_valid_in, sq_ready_in, sq_valid_out, sq_ready_out, err_stray;
    logic [15:0]         sq_operand, sq_result;
`ifdef SQRT_ARB_PERF_EN
    logic [31:0]         busy_cycles, ops_done;
`endif

    // Sqrt unit stub: one op at a time, programmable latency, optional stall / stray result
    logic                unit_busy, unit_block, force_stray;
    int unsigned         unit_cnt, unit_lat;
    logic [15:0]         unit_res;

    assign sq_ready_in  = nRST && !unit_busy && !unit_block;
    assign sq_valid_out = (unit_busy && unit_cnt == 0) || force_stray;
    assign sq_result    = unit_res;

    always #5 CLK = ~CLK;

    sqrt_bf16_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .req_valid    (req_valid),
        .req_operand  (req_operand),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .rsp_ready    (rsp_ready),
        .sq_valid_in  (sq_valid_in),
        .sq_operand   (sq_operand),
        .sq_ready_in  (sq_ready_in),
        .sq_valid_out (sq_valid_out),
        .sq_result    (sq_result),
        .sq_ready_out (sq_ready_out),
`ifdef SQRT_ARB_PERF_EN
        .busy_cycles  (busy_cycles),
        .ops_done     (ops_done),
`endif
        .err_stray    (err_stray)
    );

    int checks, errors;

    // Transaction-level model
    logic        m_busy, m_have_res, m_err;
    int          m_owner, m_last;
    logic [15:0] m_op, m_res;
    logic        rnd_mode, drop_on_grant;
    int          obs_done;

    // Per-cycle samples
    logic [N-1:0]       exp_ready;
    logic               exp_gv, s_exp_rdo;
    int                 exp_g;
    logic [N-1:0]       s_req_ready, s_rsp_valid, s_rsp_ready;
    logic [N-1:0][15:0] s_rsp_result;
    logic               s_sqvi, s_sqri, s_sqvo, s_sqro;
    logic [15:0]        s_sqop;

    // Values the stub unit returns: true BF16 roots for the directed operands
    function automatic logic [15:0] unit_fn(input logic [15:0] op);
        case (op)
            16'h3F80: return 16'h3F80;
            16'h4080: return 16'h4000;
            16'h4110: return 16'h4040;
            16'h4180: return 16'h4080;
            default:  return {op[7:0], op[15:8]} ^ 16'h5A3C;
        endcase
    endfunction

    function automatic int first_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_have_res = 1'b0;
        m_err      = 1'b0;
        m_last     = N - 1;
        m_owner    = 0;
        m_op       = '0;
        m_res      = '0;
        unit_busy  = 1'b0;
        unit_cnt   = 0;
        unit_res   = '0;
        force_stray = 1'b0;
    endtask

    // Compare every output against the model, then record handshakes for advance()
    task automatic compare();
        logic [N-1:0]       exp_rv;
        logic [N-1:0][15:0] exp_rr;
        int                 idx;
        exp_ready = '0;
        exp_gv    = 1'b0;
        exp_g     = 0;
        if (!m_busy && sq_ready_in) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_last + 1 + k) % N;
                if (!exp_gv && req_valid[idx]) begin
                    exp_gv         = 1'b1;
                    exp_g          = idx;
                    exp_ready[idx] = 1'b1;
                end
            end
        end
        exp_rv = '0;
        exp_rr = '0;
        if (m_have_res) begin
            exp_rv[m_owner] = 1'b1;
            exp_rr[m_owner] = m_res;
        end
        s_exp_rdo = m_busy && !m_have_res;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("sq_valid_in", 64'(sq_valid_in), 64'(exp_gv));
        if (exp_gv) check("sq_operand", 64'(sq_operand), 64'(req_operand[exp_g]));
        check("sq_ready_out", 64'(sq_ready_out), 64'(s_exp_rdo));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_result", 64'(rsp_result), 64'(exp_rr));
        check("err_stray", 64'(err_stray), 64'(m_err));
        s_req_ready  = req_ready;
        s_rsp_valid  = rsp_valid;
        s_rsp_result = rsp_result;
        s_rsp_ready  = rsp_ready;
        s_sqvi       = sq_valid_in;
        s_sqri       = sq_ready_in;
        s_sqvo       = sq_valid_out;
        s_sqro       = sq_ready_out;
        s_sqop       = sq_operand;
        if ((rsp_valid & rsp_ready) != '0) obs_done++;
    endtask

    // Apply what happened at the clock edge to the model, the stub and the requesters
    task automatic advance();
        if (m_have_res && s_rsp_ready[m_owner]) begin
            m_busy     = 1'b0;
            m_have_res = 1'b0;
        end else if (s_exp_rdo && s_sqvo) begin
            m_have_res = 1'b1;
            m_res      = unit_fn(m_op);
        end
        if (s_sqvo && !s_exp_rdo) m_err = 1'b1;
        if (exp_gv) begin
            m_busy  = 1'b1;
            m_owner = exp_g;
            m_op    = req_operand[exp_g];
            m_last  = exp_g;
            if (drop_on_grant) req_valid[exp_g] = 1'b0;
            else if (rnd_mode) begin
                if ($urandom_range(0, 1) == 1) req_valid[exp_g] = 1'b0;
                else req_operand[exp_g] = 16'($urandom);
            end
        end
        if (s_sqvo && s_sqro) unit_busy = 1'b0;
        else if (unit_busy && unit_cnt > 0) unit_cnt--;
        if (s_sqvi && s_sqri) begin
            unit_busy = 1'b1;
            unit_cnt  = unit_lat - 1;
            unit_res  = unit_fn(s_sqop);
        end
        if (rnd_mode) begin
            rsp_ready  = N'($urandom);
            unit_lat   = $urandom_range(1, 4);
            unit_block = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
                    req_valid[k]   = 1'b1;
                    req_operand[k] = 16'($urandom);
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        compare();
        @(posedge CLK);
        #1;
        advance();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        model_reset();
        repeat (3) tick();
        nRST = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int          pulses, other, got, ng, nr, seen, done0, gi, ri;
        logic [15:0] res;
        int          gord[5];
        int          rlane[5];
        logic [15:0] rres[5];
        int          exp_order[5];
        logic [15:0] res_tab[4];
        exp_order = '{0, 1, 2, 3, 0};
        res_tab   = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080};

        checks = 0; errors = 0; obs_done = 0;
        nRST = 1'b0;
        req_valid = '0; req_operand = '0; rsp_ready = '0;
        unit_block = 1'b0; unit_lat = 1; rnd_mode = 1'b0; drop_on_grant = 1'b0;
        model_reset();

        // Reset with all requesters idle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            check("t1_idle_outputs",
                  64'({req_ready, rsp_valid, sq_valid_in, sq_ready_out, sq_operand}), 64'(0));
            check("t1_rsp_result", 64'(rsp_result), 64'(0));
            check("t1_err_stray", 64'(err_stray), 64'(0));
        end

        // Single request from lane 2: sqrt(4.0)
        do_reset();
        drop_on_grant = 1'b1; rsp_ready = '1; unit_lat = 2;
        req_operand[2] = 16'h4080; req_valid = 4'b0100;
        pulses = 0; other = 0; got = 0; res = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (s_req_ready[2]) pulses++;
            if ((s_req_ready & 4'b1011) != '0) other++;
            if ((s_rsp_valid & 4'b1011) != '0) other++;
            if (s_rsp_result[0] != '0 || s_rsp_result[1] != '0 || s_rsp_result[3] != '0) other++;
            if (s_rsp_valid[2]) begin got++; res = s_rsp_result[2]; end
        end
        check("t2_ready_pulses", 64'(pulses), 64'(1));
        check("t2_rsp_count", 64'(got), 64'(1));
        check("t2_result", 64'(res), 64'(16'h4000));
        check("t2_other_lanes", 64'(other), 64'(0));

        // All four requesters valid: round-robin order and per-lane results
        do_reset();
        drop_on_grant = 1'b0; rsp_ready = '1;
        req_operand = {16'h4180, 16'h4110, 16'h4080, 16'h3F80};
        req_valid = '1;
        ng = 0; nr = 0;
        for (int c = 0; c < 200 && nr < 5; c++) begin
            unit_lat = $urandom_range(1, 3);
            tick();
            if (s_req_ready != '0 && ng < 5) begin gord[ng] = first_idx(s_req_ready); ng++; end
            if (s_rsp_valid != '0 && nr < 5) begin
                ri = first_idx(s_rsp_valid);
                rlane[nr] = ri;
                rres[nr]  = s_rsp_result[ri];
                nr++;
            end
        end
        check("t3_grant_count", 64'(ng), 64'(5));
        check("t3_rsp_count", 64'(nr), 64'(5));
        for (int i = 0; i < 5; i++) begin
            gi = (i < ng) ? gord[i] : -1;
            check($sformatf("t3_grant_%0d", i), 64'(gi), 64'(exp_order[i]));
            if (i < nr) begin
                check($sformatf("t3_rsp_lane_%0d", i), 64'(rlane[i]), 64'(exp_order[i]));
                check($sformatf("t3_rsp_val_%0d", i), 64'(rres[i]), 64'(res_tab[exp_order[i]]));
            end
        end

        // Response backpressure on lane 1 blocks a waiting lane 0
        do_reset();
        drop_on_grant = 1'b1; rsp_ready = '0;
        req_operand[1] = 16'h4110; req_valid = 4'b0010;
        seen = 0;
        for (int c = 0; c < 30 && seen == 0; c++) begin
            tick();
            if (s_rsp_valid[1]) seen = 1;
        end
        check("t4_resp_reached", 64'(seen), 64'(1));
        req_operand[0] = 16'h3F80; req_valid[0] = 1'b1; rsp_ready = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            tick(); #1;
            check("t4_hold_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
            check("t4_hold_rsp_result", 64'(rsp_result[1]), 64'(16'h4040));
            check("t4_no_grant", 64'(req_ready), 64'(0));
        end
        rsp_ready = '1;
        tick(); #1;
        check("t4_grant0_after_release", 64'(req_ready), 64'(4'b0001));
        for (int c = 0; c < 40 && (m_busy || req_valid != '0); c++) tick();

        // Stray unit result in IDLE sets a sticky error
        force_stray = 1'b1;
        tick();
        force_stray = 1'b0;
        tick(); #1;
        check("t5_stray_set", 64'(err_stray), 64'(1));
        for (int c = 0; c < 5; c++) begin
            tick(); #1;
            check("t5_stray_sticky", 64'(err_stray), 64'(1));
        end
        do_reset(); #1;
        check("t5_stray_cleared", 64'(err_stray), 64'(0));

        // Reset during WAIT discards state; next grant goes to lane 0
        drop_on_grant = 1'b0; rsp_ready = '1; unit_lat = 4;
        req_operand = {16'h1111, 16'h2222, 16'h4080, 16'h3333};
        req_valid = 4'b0100;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            tick();
            if (s_req_ready != '0) seen = 1;
        end
        check("t6_first_grant_seen", 64'(seen), 64'(1));
        req_valid = '1;
        tick();
        nRST = 1'b0;
        model_reset();
        #1;
        check("t6_rst_outputs",
              64'({req_ready, rsp_valid, sq_valid_in, sq_ready_out, err_stray, sq_operand}),
              64'(0));
        check("t6_rst_rsp_result", 64'(rsp_result), 64'(0));
        tick(); #1;
        check("t6_rst_hold_outputs",
              64'({req_ready, rsp_valid, sq_valid_in, sq_ready_out, err_stray}), 64'(0));
        nRST = 1'b1;
        #1;
        check("t6_grant_after_reset", 64'(req_ready), 64'(4'b0001));
        repeat (10) tick();

        // Randomized traffic against the model
        rnd_mode = 1'b1; drop_on_grant = 1'b0;
        done0 = obs_done;
        for (int c = 0; c < 3000; c++) tick();
        rnd_mode = 1'b0; rsp_ready = '1; unit_block = 1'b0; unit_lat = 1;
        for (int c = 0; c < 60; c++) tick();
        check("rnd_progress", 64'(obs_done - done0 >= 100), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_bf16_arbiter.md
# sqrt_bf16_arbiter

Shares one non-pipelined BF16 square-root unit among NUM_REQ requesters (vector lanes, microcode sequencers). It performs round-robin arbitration, issues the winning operand to the unit, tracks the single in-flight request's owner and returns the result on that requester's response channel. It sits between the requester fabric and the unit's `sqrt_if`. It keeps at most one operation in flight.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), owner-tag width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_operand  in  NUM_REQ x 16  per-requester BF16 operand
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- rsp_valid  out  NUM_REQ  per-requester result valid, one-hot or zero
- rsp_result  out  NUM_REQ x 16  per-requester BF16 result; 0 on non-owning lanes
- rsp_ready  in  NUM_REQ  per-requester result accept
- sq_valid_in  out  1  operand valid to unit
- sq_operand  out  16  operand to unit
- sq_ready_in  in  1  unit can accept an operand
- sq_valid_out  in  1  unit result valid
- sq_result  in  16  unit result
- sq_ready_out  out  1  arbiter accepts unit result
- err_stray  out  1  sticky: sq_valid_out seen outside WAIT

## Operation
- FSM states: IDLE, WAIT, RESP. All three are encoded states.
- **IDLE**
  - Grant g is the first requester with req_valid set, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - If any req_valid is set and sq_ready_in=1, drive the following in the same cycle: sq_valid_in=1, sq_operand=req_operand[g], req_ready[g]=1.
  - On the clock edge: owner<=g, rr_ptr<=(g+1) mod NUM_REQ, state<=WAIT.
  - If sq_ready_in=0, there is no grant and all req_ready are 0.
- **WAIT**
  - sq_ready_out=1 and sq_valid_in=0.
  - On sq_valid_out=1: res_q<=sq_result, state<=RESP.
- **RESP**
  - rsp_valid[owner]=1 and rsp_result[owner]=res_q.
  - On rsp_ready[owner]=1: state<=IDLE.
  - rsp_ready on other lanes is ignored.
- **Requester rules**
  - req_valid must stay asserted, with a stable operand, until req_ready.
  - A requester may keep req_valid high while its own response is pending. It is not re-granted until the FSM returns to IDLE.
- **Unit-side outputs outside their states:** sq_ready_out=0 in IDLE and RESP, and sq_valid_in=0 outside IDLE.
- **err_stray:** set when sq_valid_out=1 in IDLE or RESP. It is cleared only by nRST.
- **Owner tag:** ID_W bits, always less than NUM_REQ.

## Timing
- **Reset values:**
  - All outputs 0; err_stray=0.
  - state=IDLE, rr_ptr=0, owner=0, res_q=0.
- **Reset mid-operation:** all state is discarded immediately. The unit shares nRST, so no orphan result is expected.
- **Latency:**
  - Requester view: accept cycle to rsp_valid = (accept-to-sq_valid_out cycles of the unit) + 1.
  - Arbiter overhead: 1 cycle (the res_q register).
- **Throughput:** minimum 1 cycle in RESP plus 1 cycle in IDLE between operations. There are no back-to-back grants.
- **Same-cycle events:**
  - rsp_ready in the RESP cycle moves the FSM to IDLE. A new grant can happen no earlier than the next cycle.
  - A requester's req_valid rising in the cycle its grant would occur is served that cycle.
- **Fairness:** every continuously valid requester is granted within NUM_REQ grants.

## Configuration
- Macro: SQRT_ARB_PERF_EN.
- **Defined:**
  - Adds output busy_cycles[31:0]: cycles with state≠IDLE.
  - Adds output ops_done[31:0]: RESP handshakes.
  - Both counters saturate at all-ones and reset to 0.
- **Undefined:** ports and counters are absent, and the remaining behaviour is identical.

## Structure
- Package sqrt_arb_pkg contains:
  - typedef enum logic [1:0] arb_state_t {IDLE, WAIT, RESP}
  - localparam BF16_W=16
  - localparam NUM_REQ_DEFAULT=4
- Sub-module rr_arbiter:
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational and reused by other shared-unit schedulers.
- The top level instantiates one rr_arbiter alongside the FSM, owner register and result register.

## Test plan
- Reset with all requesters idle: every output is 0 and err_stray=0 for 10 cycles.
- Single request, req 2 with operand 0x4080 (4.0):
  - req_ready[2] pulses once.
  - rsp_valid[2] carries 0x4000.
  - All other lanes stay 0.
- All 4 requesters hold valid with operands 0x3F80, 0x4080, 0x4110, 0x4180:
  - Grant order is 0,1,2,3,0.
  - Each requester gets its own result: 0x3F80, 0x4000, 0x4040, 0x4080.
- Backpressure: rsp_ready[1]=0 for 20 cycles while requester 0 is valid.
  - The FSM holds RESP, rsp_result[1] is stable and there is no grant to 0.
  - Requester 0 is granted the cycle after rsp_ready[1] rises.
- Stray unit result: force sq_valid_out=1 in IDLE. err_stray=1 and stays set until nRST.
- Reset mid-WAIT: all outputs are 0 next cycle, and the next grant goes to requester 0.
